// File: rtl/arb_rr_oht.sv
// Round-robin arbiter with a one-hot grant that stays locked under backpressure.
// Optional burst hold controlled by macro ARB_RR_OHT_HOLD_EN.
module arb_rr_oht #(
    parameter int WIDTH = 32,
    localparam int WIDTH_LOG = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 lst,
    output logic [WIDTH-1:0]     gnt,
    output logic [WIDTH_LOG-1:0] idx,
    output logic                 vld,
    input  logic                 rdy
);

    logic [WIDTH_LOG-1:0] r_ptr;
    logic                 r_lock;
    logic [WIDTH-1:0]     r_gnt_q;

    logic [WIDTH-1:0]     w_mask;
    logic [WIDTH-1:0]     w_req_hi;
    logic [WIDTH-1:0]     w_src;
    logic [WIDTH-1:0]     w_arb;
    logic [WIDTH-1:0]     w_gnt;
    logic [WIDTH_LOG-1:0] w_idx;
    logic                 w_vld;

    // Requesters strictly above the last-served one get first pick.
    for (genvar k = 0; k < WIDTH; k++) begin : g_mask
        assign w_mask[k] = (WIDTH_LOG'(k) > r_ptr);
    end

    assign w_req_hi = req & w_mask;
    assign w_src    = (|w_req_hi) ? w_req_hi : req;
    assign w_arb    = w_src & (~w_src + WIDTH'(1));

    assign w_gnt = r_lock ? r_gnt_q : w_arb;
    assign w_vld = r_lock | (|req);

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_gnt[k]) begin
                w_idx = w_idx | WIDTH_LOG'(k);
            end
        end
    end

    assign gnt = w_gnt;
    assign idx = w_idx;
    assign vld = w_vld;

`ifdef ARB_RR_OHT_HOLD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= WIDTH_LOG'(WIDTH - 1);
            r_lock  <= 1'b0;
            r_gnt_q <= '0;
        end else if (w_vld && !rdy) begin
            r_lock  <= 1'b1;
            r_gnt_q <= w_gnt;
        end else if (w_vld && rdy) begin
            if (lst) begin
                r_ptr  <= w_idx;
                r_lock <= 1'b0;
            end else begin
                r_lock  <= 1'b1;
                r_gnt_q <= w_gnt;
            end
        end
    end
`else
    logic w_unused_lst;
    assign w_unused_lst = lst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= WIDTH_LOG'(WIDTH - 1);
            r_lock  <= 1'b0;
            r_gnt_q <= '0;
        end else if (w_vld && !rdy) begin
            r_lock  <= 1'b1;
            r_gnt_q <= w_gnt;
        end else if (w_vld && rdy) begin
            r_ptr  <= w_idx;
            r_lock <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_arb_rr_oht.sv
// Directed bench for arb_rr_oht (WIDTH=4) with a cycle-level reference model.
module tb_arb_rr_oht;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] req;
    logic         lst;
    logic [W-1:0] gnt;
    logic [1:0]   idx;
    logic         vld;
    logic         rdy;

    int n_chk;
    int n_err;

    arb_rr_oht #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .lst  (lst),
        .gnt  (gnt),
        .idx  (idx),
        .vld  (vld),
        .rdy  (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: last-served index, lock flag and locked index.
    int m_ptr;
    bit m_lock;
    int m_gidx;
    bit m_init;

    function automatic int m_pick();
        if (m_lock) return m_gidx;
        for (int i = 1; i <= W; i++) begin
            int j;
            j = (m_ptr + i) % W;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int j;
        j = m_pick();
        if (!rst_n) begin
            m_ptr  = W - 1;
            m_lock = 0;
            m_gidx = 0;
            m_init = 1;
        end else if (j >= 0) begin
            if (!rdy) begin
                m_lock = 1;
                m_gidx = j;
            end else begin
`ifdef ARB_RR_OHT_HOLD_EN
                if (lst) begin
                    m_ptr  = j;
                    m_lock = 0;
                end else begin
                    m_lock = 1;
                    m_gidx = j;
                end
`else
                m_ptr  = j;
                m_lock = 0;
`endif
            end
        end
    end

    always @(negedge clk) begin
        int j;
        logic [W-1:0] eg;
        logic [1:0]   ei;
        logic         ev;
        if (m_init) begin
            j  = m_pick();
            eg = (j < 0) ? '0 : W'(1) << j;
            ei = (j < 0) ? 2'd0 : 2'(j);
            ev = (j >= 0);
            n_chk++;
            if (gnt !== eg || idx !== ei || vld !== ev) begin
                n_err++;
                $display("FAIL model t=%0t: got gnt=%b idx=%0d vld=%b, need gnt=%b idx=%0d vld=%b",
                         $time, gnt, idx, vld, eg, ei, ev);
            end
        end
    end

    task automatic chk(string nm, logic [W-1:0] eg, logic [1:0] ei, logic ev);
        n_chk++;
        if (gnt !== eg || idx !== ei || vld !== ev) begin
            n_err++;
            $display("FAIL %s: got gnt=%b idx=%0d vld=%b, need gnt=%b idx=%0d vld=%b",
                     nm, gnt, idx, vld, eg, ei, ev);
        end
    endtask

    // Apply inputs just after a rising edge, then settle to the falling edge.
    task automatic step(logic rn, logic [W-1:0] rq, logic rd, logic ls);
        @(posedge clk);
        #1;
        rst_n = rn;
        req   = rq;
        rdy   = rd;
        lst   = ls;
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_init = 0;
        m_ptr = W - 1;
        m_lock = 0;
        m_gidx = 0;
        rst_n = 1'b0;
        req = '0;
        rdy = 1'b0;
        lst = 1'b1;

        step(0, 4'b0000, 0, 1);
        step(1, 4'b0000, 0, 1);
        chk("reset_idle", 4'b0000, 2'd0, 1'b0);

        // 1: full round robin
        step(1, 4'b1111, 1, 1); chk("rr0", 4'b0001, 2'd0, 1'b1);
        step(1, 4'b1111, 1, 1); chk("rr1", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b1111, 1, 1); chk("rr2", 4'b0100, 2'd2, 1'b1);
        step(1, 4'b1111, 1, 1); chk("rr3", 4'b1000, 2'd3, 1'b1);
        step(1, 4'b1111, 1, 1); chk("rr_wrap", 4'b0001, 2'd0, 1'b1);

        // 2: after serving index 1
        step(1, 4'b1111, 1, 1); chk("serve1", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b1010, 1, 1); chk("sparse_a", 4'b1000, 2'd3, 1'b1);
        step(1, 4'b1010, 1, 1); chk("sparse_b", 4'b0010, 2'd1, 1'b1);

        // 3: backpressure holds grant while req changes
        step(0, 4'b0000, 0, 1);
        step(1, 4'b0110, 0, 1); chk("bp_c1", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0111, 0, 1); chk("bp_c2", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0111, 0, 1); chk("bp_c3", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0111, 1, 1); chk("bp_xfer", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0111, 1, 1); chk("bp_after", 4'b0100, 2'd2, 1'b1);

        // 4: idle keeps ptr (now 2)
        step(1, 4'b0000, 1, 1); chk("idle_a", 4'b0000, 2'd0, 1'b0);
        step(1, 4'b0000, 0, 1); chk("idle_b", 4'b0000, 2'd0, 1'b0);
        step(1, 4'b1111, 1, 1); chk("idle_resume", 4'b1000, 2'd3, 1'b1);

        // Dropped request while locked keeps grant
        step(1, 4'b0010, 0, 1); chk("drop_lock", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0000, 0, 1); chk("drop_hold", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0000, 1, 1); chk("drop_xfer", 4'b0010, 2'd1, 1'b1);

        // 5: reset mid-lock overrides a simultaneous transfer
        step(1, 4'b0100, 0, 1); chk("lk_set", 4'b0100, 2'd2, 1'b1);
        step(1, 4'b0000, 0, 1); chk("lk_hold", 4'b0100, 2'd2, 1'b1);
        step(0, 4'b0000, 1, 1); chk("lk_rst_pre", 4'b0100, 2'd2, 1'b1);
        step(1, 4'b1111, 1, 1); chk("lk_rst_post", 4'b0001, 2'd0, 1'b1);

        // 6: burst vs per-beat
        step(0, 4'b0000, 0, 1);
        step(1, 4'b0011, 1, 0); chk("burst0", 4'b0001, 2'd0, 1'b1);
`ifdef ARB_RR_OHT_HOLD_EN
        step(1, 4'b0011, 1, 0); chk("burst1", 4'b0001, 2'd0, 1'b1);
        step(1, 4'b0011, 1, 1); chk("burst2", 4'b0001, 2'd0, 1'b1);
`else
        step(1, 4'b0011, 1, 0); chk("burst1", 4'b0010, 2'd1, 1'b1);
        step(1, 4'b0011, 1, 1); chk("burst2", 4'b0001, 2'd0, 1'b1);
`endif
        step(1, 4'b0011, 1, 1); chk("burst3", 4'b0010, 2'd1, 1'b1);

        step(1, 4'b0000, 0, 1); chk("end_idle", 4'b0000, 2'd0, 1'b0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
